// File: rtl/mmio_pwm_led_pkg.sv
// mmio_pwm_led_pkg: register offsets and shared widths for the memory-mapped PWM LED block.
package mmio_pwm_led_pkg;

  localparam int OFF_CTRL    = 32'sd0;
  localparam int OFF_PRESC   = 32'sd1;
  localparam int OFF_DUTY0   = 32'sd2;
  localparam int BLINK_CNT_W = 32'sd8;

endpackage

// File: rtl/mmio_pwm_led_if.sv
// mmio_pwm_led_if: single-cycle strobe CPU bus with registered read response.
interface mmio_pwm_led_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output write, read, address, wdata, input rdata, rvalid);
  modport slave  (input write, read, address, wdata, output rdata, rvalid);

endinterface

// File: rtl/pwm_channel.sv
// pwm_channel: one LED channel; latches the duty shadow at period start and drives a registered
// active-low LED bit from the compare against the shared PWM counter.
module pwm_channel #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PWM_W-1:0] duty,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             en,
  input  logic             force_off,
  output logic             led_n
);

  logic [PWM_W-1:0] active_r;
  logic             on_s;

  assign on_s = en && !force_off && (pwm_cnt < active_r);

  // Active duty only changes on the wrap tick, so a period never sees a mid-period duty write.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r <= '0;
      led_n    <= 1'b1;
    end else begin
      if (load) begin
        active_r <= duty;
      end
      led_n <= ~on_s;
    end
  end

endmodule

// File: rtl/mmio_pwm_led.sv
// mmio_pwm_led: MMIO register bank, prescaler and shared PWM counter driving CHANNELS LEDs.
// Define LED_BLINK_EN to add the BLINK register and the per-period blink counter.
module mmio_pwm_led
  import mmio_pwm_led_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h80,
  parameter int                CHANNELS  = 3,
  parameter int                PWM_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  mmio_pwm_led_if.slave       bus,
  output logic [CHANNELS-1:0] led_n
);

  logic [ADDR_W-1:0]   off_s;
  logic                ctrl_sel_s;
  logic                presc_sel_s;
  logic [CHANNELS-1:0] duty_sel_s;
  logic [CHANNELS-1:0] ctrl_r;
  logic [DATA_W-1:0]   presc_r;
  logic [DATA_W-1:0]   presc_cnt_r;
  logic [PWM_W-1:0]    duty_r [CHANNELS];
  logic [PWM_W-1:0]    pwm_cnt_r;
  logic                tick_s;
  logic                wrap_s;
  logic [DATA_W-1:0]   rd_mux_s;
  logic [DATA_W-1:0]   blink_rd_s;
  logic [DATA_W-1:0]   rdata_r;
  logic                rvalid_r;
  logic [CHANNELS-1:0] force_off_s;

  // Address decode relative to the block base; addresses below base wrap to unmapped offsets.
  always_comb begin
    off_s       = bus.address - BASE_ADDR;
    ctrl_sel_s  = (off_s == ADDR_W'(OFF_CTRL));
    presc_sel_s = (off_s == ADDR_W'(OFF_PRESC));
    for (int i = 32'sd0; i < CHANNELS; i++) begin
      duty_sel_s[i] = (off_s == ADDR_W'(OFF_DUTY0 + i));
    end
  end

`ifdef LED_BLINK_EN
  logic                   blink_sel_s;
  logic [CHANNELS-1:0]    blink_r;
  logic [BLINK_CNT_W-1:0] blink_cnt_r;

  assign blink_sel_s = (off_s == ADDR_W'(OFF_DUTY0 + CHANNELS));
  assign force_off_s = blink_r & {CHANNELS{blink_cnt_r[BLINK_CNT_W-1]}};
  assign blink_rd_s  = blink_sel_s ? DATA_W'(blink_r) : '0;

  // Blink mask register and the counter of completed PWM periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_r     <= '0;
      blink_cnt_r <= '0;
    end else begin
      if (bus.write && blink_sel_s) begin
        blink_r <= bus.wdata[CHANNELS-1:0];
      end
      if (wrap_s) begin
        blink_cnt_r <= blink_cnt_r + BLINK_CNT_W'(1);
      end
    end
  end
`else
  assign force_off_s = '0;
  assign blink_rd_s  = '0;
`endif

  // Read mux: at most one select is hot, so the contributions are OR-ed together.
  always_comb begin
    rd_mux_s = blink_rd_s
             | (ctrl_sel_s  ? DATA_W'(ctrl_r) : '0)
             | (presc_sel_s ? presc_r         : '0);
    for (int i = 32'sd0; i < CHANNELS; i++) begin
      rd_mux_s = rd_mux_s | (duty_sel_s[i] ? DATA_W'(duty_r[i]) : '0);
    end
  end

  // Register bank writes; unmapped offsets match no select and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r  <= '0;
      presc_r <= '0;
      for (int i = 32'sd0; i < CHANNELS; i++) begin
        duty_r[i] <= '0;
      end
    end else if (bus.write) begin
      if (ctrl_sel_s) begin
        ctrl_r <= bus.wdata[CHANNELS-1:0];
      end
      if (presc_sel_s) begin
        presc_r <= bus.wdata;
      end
      for (int i = 32'sd0; i < CHANNELS; i++) begin
        if (duty_sel_s[i]) begin
          duty_r[i] <= bus.wdata[PWM_W-1:0];
        end
      end
    end
  end

  // Read response; a simultaneous write wins and suppresses the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= bus.read && !bus.write;
      if (bus.read && !bus.write) begin
        rdata_r <= rd_mux_s;
      end
    end
  end

  assign bus.rdata  = rdata_r;
  assign bus.rvalid = rvalid_r;

  assign tick_s = (presc_cnt_r == presc_r);
  assign wrap_s = tick_s && (pwm_cnt_r == '1);

  // Prescaler restarts on any PRESC write; the PWM counter keeps its position.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_r <= '0;
      pwm_cnt_r   <= '0;
    end else begin
      if ((bus.write && presc_sel_s) || tick_s) begin
        presc_cnt_r <= '0;
      end else begin
        presc_cnt_r <= presc_cnt_r + DATA_W'(1);
      end
      if (tick_s) begin
        pwm_cnt_r <= pwm_cnt_r + PWM_W'(1);
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(
      .PWM_W (PWM_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load      (wrap_s),
      .duty      (duty_r[g]),
      .pwm_cnt   (pwm_cnt_r),
      .en        (ctrl_r[g]),
      .force_off (force_off_s[g]),
      .led_n     (led_n[g])
    );
  end

endmodule

// File: tb/tb_mmio_pwm_led.sv
// tb_mmio_pwm_led: directed and random MMIO traffic compared each clock against a tick/period model.
module tb_mmio_pwm_led;

  localparam int         CH   = 3;
  localparam logic [7:0] BASE = 8'h80;
`ifdef LED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] led_n;

  mmio_pwm_led_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mmio_pwm_led #(
    .ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h80), .CHANNELS(CH), .PWM_W(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .led_n(led_n)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: registers plus total ticks since reset; counter and period derive from it.
  int unsigned   m_ctrl, m_presc, m_blink, m_ticks, m_clk;
  int unsigned   m_duty [CH];
  int unsigned   m_active [CH];
  logic [7:0]    m_rdata;
  logic          m_rvalid;
  logic [CH-1:0] m_led;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    logic [7:0] o;
    o = a - BASE;
    if (o == 8'd0) return 8'(m_ctrl);
    if (o == 8'd1) return 8'(m_presc);
    if (o >= 8'd2 && o < 8'(2 + CH)) return 8'(m_duty[o - 8'd2]);
    if (BLINK && o == 8'(2 + CH)) return 8'(m_blink);
    return 8'h00;
  endfunction

  // Returns 1 when the write hit PRESC (prescaler restart).
  function automatic bit m_write(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] o;
    o = a - BASE;
    if (o == 8'd0) m_ctrl = d & ((1 << CH) - 1);
    else if (o == 8'd1) begin m_presc = d; return 1'b1; end
    else if (o >= 8'd2 && o < 8'(2 + CH)) m_duty[o - 8'd2] = d;
    else if (BLINK && o == 8'(2 + CH)) m_blink = d & ((1 << CH) - 1);
    return 1'b0;
  endfunction

  function automatic void model_edge();
    int unsigned pos;
    bit          blanked, tick, restart;
    pos     = m_ticks % 256;
    blanked = BLINK && (((m_ticks / 256) % 256) >= 128);
    for (int i = 0; i < CH; i++)
      m_led[i] = !((((m_ctrl >> i) & 1) != 0) && pos < m_active[i] &&
                   !(blanked && (((m_blink >> i) & 1) != 0)));
    if (rst) begin
      m_ctrl = 0; m_presc = 0; m_blink = 0; m_ticks = 0; m_clk = 0;
      m_rdata = 8'h00; m_rvalid = 1'b0; m_led = '1;
      for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_active[i] = 0; end
    end else begin
      m_rvalid = bus.read && !bus.write;
      if (m_rvalid) m_rdata = m_read(bus.address);
      tick = ((m_clk + 1) % (m_presc + 1)) == 0;
      if (tick) begin
        if (pos == 255) for (int i = 0; i < CH; i++) m_active[i] = m_duty[i];
        m_ticks++;
      end
      restart = bus.write ? m_write(bus.address, bus.wdata) : 1'b0;
      m_clk = restart ? 0 : m_clk + 1;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("led_n", 32'(led_n), 32'(m_led));
    check_eq("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
    check_eq("rdata", 32'(bus.rdata), 32'(m_rdata));
  endtask

  task automatic bus_op(input bit w, input bit r, input logic [7:0] a, input logic [7:0] d);
    bus.write = w; bus.read = r; bus.address = a; bus.wdata = d;
    step();
    bus.write = 1'b0; bus.read = 1'b0;
  endtask

  task automatic sync_pos(input int unsigned p, input string tag);
    int k;
    k = 0;
    while ((m_ticks % 256) != p && k < 3000) begin step(); k++; end
    check_eq(tag, m_ticks % 256, p);
  endtask

  task automatic count_low(input int n, output int low0, output int low12);
    low0 = 0; low12 = 0;
    repeat (n) begin
      step();
      if (led_n[0] == 1'b0) low0++;
      if (led_n[2:1] != 2'b11) low12++;
    end
  endtask

  initial begin
    int          low0, low12, sel;
    logic [7:0]  a, d;
    bus.write = 1'b0; bus.read = 1'b0; bus.address = 8'h00; bus.wdata = 8'h00;
    repeat (2) step();
    rst = 1'b0;

    bus_op(1'b0, 1'b1, BASE, 8'h00);
    check_eq("r035_rvalid", 32'(bus.rvalid), 32'd1);
    check_eq("r035_rdata", 32'(bus.rdata), 32'd0);
    check_eq("r035_led", 32'(led_n), 32'h7);

    bus_op(1'b1, 1'b0, BASE, 8'h07);
    bus_op(1'b1, 1'b0, BASE + 8'd1, 8'h00);
    bus_op(1'b1, 1'b0, BASE + 8'd2, 8'h40);
    sync_pos(0, "r036_sync");
    count_low(256, low0, low12);
    check_eq("r036_low64", 32'(low0), 32'd64);
    check_eq("r036_others_off", 32'(low12), 32'd0);

    sync_pos(16, "r037_sync16");
    bus_op(1'b1, 1'b0, BASE + 8'd2, 8'hC0);
    sync_pos(0, "r037_sync0");
    count_low(256, low0, low12);
    check_eq("r037_low192", 32'(low0), 32'd192);

    bus_op(1'b1, 1'b1, BASE + 8'd1, 8'h03);
    check_eq("r038_rvalid0", 32'(bus.rvalid), 32'd0);
    bus_op(1'b0, 1'b1, BASE + 8'd1, 8'h00);
    check_eq("r038_presc", 32'(bus.rdata), 32'h03);
    repeat (8) step();
    count_low(1024, low0, low12);
    check_eq("r038_low768", 32'(low0), 32'd768);

    bus_op(1'b0, 1'b1, BASE + 8'h20, 8'h00);
    check_eq("r039_rvalid", 32'(bus.rvalid), 32'd1);
    check_eq("r039_rdata", 32'(bus.rdata), 32'd0);
    bus_op(1'b1, 1'b0, BASE + 8'h20, 8'hFF);
    bus_op(1'b0, 1'b1, BASE, 8'h00);
    check_eq("r039_ctrl", 32'(bus.rdata), 32'h07);
    for (int o = 0; o < 8; o++) bus_op(1'b0, 1'b1, BASE + 8'(o), 8'h00);

    bus_op(1'b0, 1'b1, BASE + 8'(2 + CH), 8'h00);
`ifndef LED_BLINK_EN
    check_eq("r040_noblink", 32'(bus.rdata), 32'd0);
`else
    bus_op(1'b1, 1'b0, BASE + 8'd1, 8'h00);
    bus_op(1'b1, 1'b0, BASE + 8'd2, 8'hFF);
    bus_op(1'b1, 1'b0, BASE, 8'h01);
    bus_op(1'b1, 1'b0, BASE + 8'(2 + CH), 8'h01);
    repeat (256 * 130) step();
`endif

    // Reset during a read cancels it; a write during reset is dropped.
    rst = 1'b1;
    bus_op(1'b0, 1'b1, BASE, 8'h00);
    check_eq("r030_rvalid", 32'(bus.rvalid), 32'd0);
    bus_op(1'b1, 1'b0, BASE, 8'h07);
    rst = 1'b0;
    bus_op(1'b0, 1'b1, BASE, 8'h00);
    check_eq("r030_ctrl", 32'(bus.rdata), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 99);
      a   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 6));
      d   = 8'($urandom);
      if (a == BASE + 8'd1) d = 8'($urandom_range(0, 3));
      if (sel < 1) begin rst = 1'b1; step(); rst = 1'b0; end
      else if (sel < 35) bus_op(1'b1, 1'b0, a, d);
      else if (sel < 60) bus_op(1'b0, 1'b1, a, d);
      else if (sel < 65) bus_op(1'b1, 1'b1, a, d);
      else step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
